// File: rtl/ext_int_source_if.sv
// Interrupt-ack channel between mips (master) and the external interrupt source (slave).
// The master drives the ack store address/byte enables; the slave returns the interrupt level.
interface ext_int_source_if;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic        interrupt;

  modport master (output m_int_addr, output m_int_byteen, input interrupt);
  modport slave  (input m_int_addr, input m_int_byteen, output interrupt);
endinterface

// File: rtl/ext_int_source.sv
// External interrupt source: counts trig edges, holds interrupt while events are pending, retires one per ack.
// Optional macro EXT_INT_AUTO_EN adds a free-running PERIOD-cycle auto-trigger ORed into the event.
module ext_int_source #(
  parameter logic [31:0] ACK_ADDR = 32'h0000_7f20,
  parameter int          DEPTH    = 4,
  parameter int          GAP_CYC  = 2,
  parameter int          PERIOD   = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  ext_int_source_if.slave   bus,
  output logic [2:0]        pend_cnt,
  output logic              overflow,
  output logic              spurious
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [2:0] DEPTH_L  = 3'(DEPTH);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYC - 1);

  logic [1:0] r_state;
  logic [1:0] w_stateNext;
  logic       r_trigQ;
  logic [3:0] r_gapCnt;
  logic [3:0] w_gapNext;
  logic [2:0] r_pendCnt;
  logic [2:0] w_pendNext;
  logic       r_overflow;
  logic       r_spurious;
  logic       r_interrupt;
  logic       w_extEv;
  logic       w_ev;
  logic       w_ackHit;
  logic       w_ackValid;
  logic       w_ackSpur;
  logic       w_ovfSet;

  assign w_extEv = trig & ~r_trigQ;

`ifdef EXT_INT_AUTO_EN
  localparam int                AUTO_W    = $clog2(PERIOD);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(PERIOD - 1);

  logic [AUTO_W-1:0] r_autoCnt;
  logic              w_autoEv;

  // A coincident auto and external event merge into a single event.
  assign w_autoEv = (r_autoCnt == AUTO_LAST);
  assign w_ev     = w_extEv | w_autoEv;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_autoCnt <= '0;
    end else if (w_autoEv) begin
      r_autoCnt <= '0;
    end else begin
      r_autoCnt <= r_autoCnt + 1'b1;
    end
  end
`else
  assign w_ev = w_extEv;
`endif

  assign w_ackHit   = (bus.m_int_addr == ACK_ADDR) && (bus.m_int_byteen != 4'b0000);
  assign w_ackValid = w_ackHit && (r_state == REQ);
  assign w_ackSpur  = w_ackHit && (r_state != REQ);

  always_comb begin
    w_pendNext = r_pendCnt;
    w_ovfSet   = 1'b0;
    if (w_ev && !w_ackValid) begin
      if (r_pendCnt == DEPTH_L) begin
        w_ovfSet = 1'b1;
      end else begin
        w_pendNext = r_pendCnt + 3'd1;
      end
    end else if (w_ackValid && !w_ev) begin
      w_pendNext = r_pendCnt - 3'd1;
    end
  end

  // GAP forces a fresh low period after every ack so the CPU sees a new level per event.
  always_comb begin
    w_stateNext = r_state;
    w_gapNext   = r_gapCnt;
    case (r_state)
      IDLE: begin
        if (w_ev) begin
          w_stateNext = REQ;
        end
      end
      REQ: begin
        if (w_ackValid) begin
          w_stateNext = GAP;
          w_gapNext   = GAP_LOAD;
        end
      end
      GAP: begin
        if (r_gapCnt == 4'd0) begin
          w_stateNext = (w_pendNext != 3'd0) ? REQ : IDLE;
        end else begin
          w_gapNext = r_gapCnt - 4'd1;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_trigQ     <= 1'b0;
      r_gapCnt    <= 4'd0;
      r_pendCnt   <= 3'd0;
      r_overflow  <= 1'b0;
      r_spurious  <= 1'b0;
      r_interrupt <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_trigQ     <= trig;
      r_gapCnt    <= w_gapNext;
      r_pendCnt   <= w_pendNext;
      r_overflow  <= r_overflow | w_ovfSet;
      r_spurious  <= r_spurious | w_ackSpur;
      r_interrupt <= (w_stateNext == REQ);
    end
  end

  assign bus.interrupt = r_interrupt;
  assign pend_cnt      = r_pendCnt;
  assign overflow      = r_overflow;
  assign spurious      = r_spurious;

endmodule

// File: tb/tb_ext_int_source.sv
// Scoreboard bench for ext_int_source: directed scenarios plus randomized traffic against an event-level model.
module tb_ext_int_source;

  localparam logic [31:0] ACK    = 32'h0000_7f20;
  localparam int          DEPTH  = 4;
  localparam int          GAP    = 2;
  localparam int          PERIOD = 10;

  typedef struct {
    logic       irq;
    logic [2:0] pend;
    logic       ovf;
    logic       spur;
    int         phase;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       trig;
  logic [2:0] pend_cnt;
  logic       overflow;
  logic       spurious;

  ext_int_source_if bus ();

  ext_int_source #(
    .ACK_ADDR (ACK),
    .DEPTH    (DEPTH),
    .GAP_CYC  (GAP),
    .PERIOD   (PERIOD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .trig     (trig),
    .bus      (bus),
    .pend_cnt (pend_cnt),
    .overflow (overflow),
    .spurious (spurious)
  );

  always #5 clk = ~clk;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   phase = 0;

  // Model: interrupt is high whenever events are pending and the post-ack hold-off has elapsed.
  int mPend = 0;
  bit mOvf = 0;
  bit mSpur = 0;
  bit mIrq = 0;
  bit mPrevTrig = 0;
  int mEdge = 0;
  int mHoldEnd = 0;
  int mAuto = 0;

  task automatic applyStimulus(input logic r, input logic t, input logic [31:0] a, input logic [3:0] be);
    exp_t e;
    bit ev;
    bit hit;
    bit valid;
    @(negedge clk);
    reset = r;
    trig = t;
    bus.m_int_addr = a;
    bus.m_int_byteen = be;
    mEdge++;
    if (r) begin
      mPend = 0; mOvf = 0; mSpur = 0; mIrq = 0; mPrevTrig = 0; mHoldEnd = mEdge; mAuto = 0;
    end else begin
      ev = t && !mPrevTrig;
      mPrevTrig = t;
`ifdef EXT_INT_AUTO_EN
      if (mAuto == PERIOD - 1) begin
        ev = 1'b1;
        mAuto = 0;
      end else begin
        mAuto++;
      end
`endif
      hit = (a == ACK) && (be != 4'b0000);
      valid = hit && mIrq;
      if (hit && !mIrq) mSpur = 1;
      if (ev && !valid) begin
        if (mPend == DEPTH) mOvf = 1;
        else mPend++;
      end else if (valid && !ev) begin
        mPend--;
      end
      if (valid) mHoldEnd = mEdge + GAP;
      mIrq = (mPend > 0) && (mEdge >= mHoldEnd);
    end
    e.irq = mIrq;
    e.pend = 3'(mPend);
    e.ovf = mOvf;
    e.spur = mSpur;
    e.phase = phase;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (bus.interrupt !== e.irq) begin
      miscompares++;
      $display("[TB] FAIL interrupt phase %0d: got %b expected %b", e.phase, bus.interrupt, e.irq);
    end
    if (pend_cnt !== e.pend) begin
      miscompares++;
      $display("[TB] FAIL pend_cnt phase %0d: got %0d expected %0d", e.phase, pend_cnt, e.pend);
    end
    if (overflow !== e.ovf) begin
      miscompares++;
      $display("[TB] FAIL overflow phase %0d: got %b expected %b", e.phase, overflow, e.ovf);
    end
    if (spurious !== e.spur) begin
      miscompares++;
      $display("[TB] FAIL spurious phase %0d: got %b expected %b", e.phase, spurious, e.spur);
    end
  endtask

  // Monitor: one expected record per clock edge, compared just after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic pulseTrig(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0, 4'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);
    end
  endtask

  task automatic waitIrq();
    for (int i = 0; i < 20 && !mIrq; i++) idle(1);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 4'h0);
  endtask

  initial begin
    reset = 1'b1;
    trig = 1'b0;
    bus.m_int_addr = 32'h0;
    bus.m_int_byteen = 4'h0;

    phase = 1;
    doReset();
    idle(3);
    pulseTrig(1);
    idle(3);

    phase = 2;
    applyStimulus(1'b0, 1'b0, ACK, 4'b0001);
    idle(5);

    phase = 3;
    pulseTrig(3);
    for (int k = 0; k < 3; k++) begin
      waitIrq();
      applyStimulus(1'b0, 1'b0, ACK, 4'b0001);
    end
    idle(5);

    phase = 4;
    pulseTrig(6);
    idle(4);

    phase = 5;
    applyStimulus(1'b0, 1'b0, ACK + 32'h4, 4'b1111);
    applyStimulus(1'b0, 1'b0, ACK, 4'b0000);
    idle(2);
    doReset();
    applyStimulus(1'b0, 1'b0, ACK, 4'b1000);
    idle(2);

    phase = 6;
    doReset();
    pulseTrig(2);
    applyStimulus(1'b0, 1'b1, ACK, 4'b0010);
    idle(4);
    applyStimulus(1'b0, 1'b0, ACK, 4'b0100);
    applyStimulus(1'b1, 1'b1, 32'h0, 4'h0);
    idle(3);

    phase = 7;
    pulseTrig(2);
    waitIrq();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, ACK, 4'b0011);
    idle(6);

    phase = 8;
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic t;
      logic [31:0] a;
      logic [3:0] be;
      r = ($urandom_range(0, 199) == 0);
      t = ($urandom_range(0, 2) == 0);
      a = 32'h0;
      be = 4'(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15));
      case ($urandom_range(0, 5))
        0, 1: a = ACK;
        2:    a = ACK + 32'h4;
        3:    a = $urandom;
        default: a = 32'h0;
      endcase
      applyStimulus(r, t, a, be);
    end
    idle(2);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    if (expQ.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d records left, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
